mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus of the two-port memory arbiter.
// slave  : the arbiter side (takes requests, drives grants and the memory port).
// master : the environment side (requesters plus the data memory).
//
// Handshake: reqN is a level that stays high while requester N still has
// beats to issue. A beat is transferred in every cycle where gntN && reqN,
// with no wait states. wrN/addrN/wdataN describe that beat. Read data comes
// back one cycle later as rdataN, qualified by a one-cycle rvalidN pulse.
// state_dbg mirrors the arbiter FSM: 0 = idle, 1 = requester 0 owns,
// 2 = requester 1 owns.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0;
    logic          wr0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic [DW-1:0] rdata0;
    logic          rvalid0;

    logic          req1;
    logic          wr1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic [DW-1:0] rdata1;
    logic          rvalid1;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_Din;
    logic          mem_memWrt;
    logic [DW-1:0] mem_Dout;

    logic [1:0]    state_dbg;

    modport slave (
        input  req0, wr0, addr0, wdata0,
        input  req1, wr1, addr1, wdata1,
        input  mem_Dout,
        output gnt0, rdata0, rvalid0,
        output gnt1, rdata1, rvalid1,
        output mem_addr, mem_Din, mem_memWrt,
        output state_dbg
    );

    modport master (
        output req0, wr0, addr0, wdata0,
        output req1, wr1, addr1, wdata1,
        output mem_Dout,
        input  gnt0, rdata0, rvalid0,
        input  gnt1, rdata1, rvalid1,
        input  mem_addr, mem_Din, mem_memWrt,
        input  state_dbg
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// One owner at a time; the owner issues one beat per cycle while its request
// is high. An owner is preempted after MAX_BURST consecutive beats only if
// the other requester is waiting; otherwise it keeps the memory indefinitely.
// Optional feature macro MEM_ARB_RR_EN: a simultaneous request seen in IDLE
// goes to the requester that was not granted last. Without it, requester 0
// always wins that tie.
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [4:0] BURST_LIMIT = 5'(MAX_BURST);

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    beat_cnt;
    logic [4:0]    beat_cnt_inc;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          beat0;
    logic          beat1;
    logic          tie_to1;

    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_din_c;
    logic          mem_wrt_c;

    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          rvalid0_q;
    logic          rvalid1_q;

    assign beat0        = gnt0_q & bus.req0;
    assign beat1        = gnt1_q & bus.req1;
    assign beat_cnt_inc = {1'b0, beat_cnt} + 5'd1;

`ifdef MEM_ARB_RR_EN
    logic last_gnt;

    assign tie_to1 = ~last_gnt;

    // Remember which requester was granted most recently; resets to 1 so the
    // first tie after reset goes to requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (state_nxt == OWN0 && state != OWN0) begin
            last_gnt <= 1'b0;
        end else if (state_nxt == OWN1 && state != OWN1) begin
            last_gnt <= 1'b1;
        end
    end
`else
    assign tie_to1 = 1'b0;
`endif

    // Next owner: release on dropped request, preempt at the burst limit
    // only when the other side is waiting.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_nxt = tie_to1 ? OWN1 : OWN0;
                end else if (bus.req0) begin
                    state_nxt = OWN0;
                end else if (bus.req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!bus.req0) begin
                    state_nxt = bus.req1 ? OWN1 : IDLE;
                end else if (bus.req1 && beat_cnt_inc == BURST_LIMIT) begin
                    state_nxt = OWN1;
                end
            end
            OWN1: begin
                if (!bus.req1) begin
                    state_nxt = bus.req0 ? OWN0 : IDLE;
                end else if (bus.req0 && beat_cnt_inc == BURST_LIMIT) begin
                    state_nxt = OWN0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbiter FSM with registered grants and the per-ownership beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            beat_cnt <= 4'd0;
        end else begin
            state  <= state_nxt;
            gnt0_q <= (state_nxt == OWN0);
            gnt1_q <= (state_nxt == OWN1);
            if (state_nxt != state && state_nxt != IDLE) begin
                beat_cnt <= 4'd0;
            end else if ((beat0 || beat1) && beat_cnt != 4'hF) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
        end
    end

    // Memory port mux: only a live beat reaches the memory, otherwise all zero.
    always_comb begin
        mem_addr_c = '0;
        mem_din_c  = '0;
        mem_wrt_c  = 1'b0;
        if (beat0) begin
            mem_addr_c = bus.addr0;
            mem_din_c  = bus.wdata0;
            mem_wrt_c  = bus.wr0;
        end else if (beat1) begin
            mem_addr_c = bus.addr1;
            mem_din_c  = bus.wdata1;
            mem_wrt_c  = bus.wr1;
        end
    end

    // Capture read data one cycle after each read beat; rdata holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= beat0 & ~bus.wr0;
            rvalid1_q <= beat1 & ~bus.wr1;
            if (beat0 && !bus.wr0) begin
                rdata0_q <= bus.mem_Dout;
            end
            if (beat1 && !bus.wr1) begin
                rdata1_q <= bus.mem_Dout;
            end
        end
    end

    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.rdata0     = rdata0_q;
    assign bus.rdata1     = rdata1_q;
    assign bus.rvalid0    = rvalid0_q;
    assign bus.rvalid1    = rvalid1_q;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_Din    = mem_din_c;
    assign bus.mem_memWrt = mem_wrt_c;
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus random two-port traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data memory: combinational read, write on rising clock, 16 words.
    logic [DW-1:0] mem [16];
    assign bus.mem_Dout = mem[bus.mem_addr[3:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (bus.mem_memWrt) begin
            mem[bus.mem_addr[3:0]] <= bus.mem_Din;
        end
    end

    // ---------------- reference model ----------------
    int            m_own;      // -1 idle, else owning requester
    int            m_cnt;      // beats in current ownership
    int            m_last;     // last granted requester
    bit            m_pend0, m_pend1;
    bit            m_b0, m_b1;
    logic [DW-1:0] m_rd0, m_rd1;
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];

    logic          e_gnt0, e_gnt1, e_wrt, e_rv0, e_rv1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;

    task automatic model_reset();
        m_own = -1; m_cnt = 0; m_last = 1;
        m_pend0 = 0; m_pend1 = 0; m_rd0 = '0; m_rd1 = '0;
        exp_q0.delete(); exp_q1.delete();
    endtask

    function automatic int tie_winner();
`ifdef MEM_ARB_RR_EN
        return (m_last == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Expected outputs for the current cycle from model state and inputs.
    task automatic model_eval();
        e_gnt0 = (m_own == 0);
        e_gnt1 = (m_own == 1);
        m_b0 = e_gnt0 && bus.req0;
        m_b1 = e_gnt1 && bus.req1;
        e_addr = m_b0 ? bus.addr0  : (m_b1 ? bus.addr1  : '0);
        e_din  = m_b0 ? bus.wdata0 : (m_b1 ? bus.wdata1 : '0);
        e_wrt  = m_b0 ? bus.wr0    : (m_b1 ? bus.wr1    : 1'b0);
        e_rv0 = m_pend0;
        e_rv1 = m_pend1;
        if (m_pend0 && exp_q0.size() > 0) m_rd0 = exp_q0.pop_front();
        if (m_pend1 && exp_q1.size() > 0) m_rd1 = exp_q1.pop_front();
    endtask

    // Apply the rising edge to the model, then wait for the next sample point.
    task automatic advance();
        int  nxt;
        bit  mine, other;
        if (m_b0) begin
            if (bus.wr0) ref_mem[bus.addr0[3:0]] = bus.wdata0;
            else exp_q0.push_back(ref_mem[bus.addr0[3:0]]);
        end
        if (m_b1) begin
            if (bus.wr1) ref_mem[bus.addr1[3:0]] = bus.wdata1;
            else exp_q1.push_back(ref_mem[bus.addr1[3:0]]);
        end
        m_pend0 = m_b0 && !bus.wr0;
        m_pend1 = m_b1 && !bus.wr1;
        if (m_own < 0) begin
            if (bus.req0 && bus.req1) nxt = tie_winner();
            else if (bus.req0) nxt = 0;
            else if (bus.req1) nxt = 1;
            else nxt = -1;
        end else begin
            mine  = (m_own == 0) ? bus.req0 : bus.req1;
            other = (m_own == 0) ? bus.req1 : bus.req0;
            if (!mine) nxt = other ? 1 - m_own : -1;
            else if (other && (m_cnt + 1) == MAX_BURST) nxt = 1 - m_own;
            else nxt = m_own;
        end
        if (nxt >= 0 && nxt != m_own) begin
            m_cnt = 0; m_last = nxt;
        end else if (m_b0 || m_b1) begin
            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        end
        m_own = nxt;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req0 = 0; bus.wr0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.wr1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic apply_reset();
        rst = 1; mem_clr = 1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        mem_clr = 0; rst = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; mem_clr = 1;
        idle_inputs();
        bus.req0 = 1; bus.wr0 = 1; bus.addr0 = 32'h5; bus.req1 = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++; if (bus.gnt0 !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt0: got %0b want 0", bus.gnt0); end
        tests_run++; if (bus.gnt1 !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt1: got %0b want 0", bus.gnt1); end
        tests_run++; if (bus.mem_memWrt !== 1'b0) begin tests_failed++; $display("FAIL reset_memwrt: got %0b want 0", bus.mem_memWrt); end
        tests_run++; if (bus.mem_addr !== '0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
        tests_run++; if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin tests_failed++; $display("FAIL reset_rvalid: got %b want 00", {bus.rvalid0, bus.rvalid1}); end
        tests_run++; if (bus.rdata0 !== '0 || bus.rdata1 !== '0) begin tests_failed++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.rdata0, bus.rdata1); end
        @(negedge clk);
        mem_clr = 0; rst = 0;
        idle_inputs();
    endtask

    task automatic test_write_read();
        apply_reset();
        bus.req0 = 1; bus.wr0 = 1; bus.addr0 = '0; bus.wdata0 = 32'h1248;
        #1; model_eval();
        tests_run++; if (bus.gnt0 !== 1'b0) begin tests_failed++; $display("FAIL wr_c0_gnt0: got %0b want 0", bus.gnt0); end
        advance();
        #1; model_eval();
        tests_run++; if (bus.gnt0 !== 1'b1) begin tests_failed++; $display("FAIL wr_c1_gnt0: got %0b want 1", bus.gnt0); end
        tests_run++; if (bus.mem_memWrt !== 1'b1) begin tests_failed++; $display("FAIL wr_c1_memwrt: got %0b want 1", bus.mem_memWrt); end
        tests_run++; if (bus.mem_addr !== 32'h0 || bus.mem_Din !== 32'h1248) begin tests_failed++; $display("FAIL wr_c1_bus: got %h/%h want 0/1248", bus.mem_addr, bus.mem_Din); end
        advance();
        bus.wr0 = 0;
        #1; model_eval();
        tests_run++; if (bus.mem_memWrt !== 1'b0 || bus.gnt0 !== 1'b1) begin tests_failed++; $display("FAIL rd_c2_beat: got wrt=%0b gnt0=%0b want 0/1", bus.mem_memWrt, bus.gnt0); end
        tests_run++; if (bus.rvalid0 !== 1'b0) begin tests_failed++; $display("FAIL rd_c2_rvalid: got %0b want 0", bus.rvalid0); end
        advance();
        bus.req0 = 0;
        #1; model_eval();
        tests_run++; if (bus.rvalid0 !== 1'b1) begin tests_failed++; $display("FAIL rd_c3_rvalid: got %0b want 1", bus.rvalid0); end
        tests_run++; if (bus.rdata0 !== 32'h1248) begin tests_failed++; $display("FAIL rd_c3_rdata: got %h want 1248", bus.rdata0); end
        advance();
        #1; model_eval();
        tests_run++; if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 32'h1248) begin tests_failed++; $display("FAIL rd_c4_hold: got rv=%0b rd=%h want 0/1248", bus.rvalid0, bus.rdata0); end
        tests_run++; if (bus.gnt0 !== 1'b0) begin tests_failed++; $display("FAIL rd_c4_release: got %0b want 0", bus.gnt0); end
        advance();
    endtask

    task automatic test_burst_alternation();
        int rem0, rem1;
        logic want0;
        apply_reset();
        rem0 = 8; rem1 = 8;
        for (int k = 0; k < 18; k++) begin
            bus.req0 = (rem0 > 0); bus.wr0 = 0; bus.addr0 = 32'($urandom_range(0, 15));
            bus.req1 = (rem1 > 0); bus.wr1 = 1; bus.addr1 = 32'($urandom_range(0, 15));
            bus.wdata1 = $urandom;
            #1; model_eval();
            if (k >= 1 && k <= 16) begin
                want0 = (((k - 1) / MAX_BURST) % 2) == 0;
                tests_run++; if (bus.gnt0 !== want0 || bus.gnt1 !== !want0) begin tests_failed++; $display("FAIL burst_k%0d_gnt: got %0b%0b want %0b%0b", k, bus.gnt0, bus.gnt1, want0, !want0); end
                tests_run++; if (bus.mem_addr !== e_addr || bus.mem_memWrt !== e_wrt) begin tests_failed++; $display("FAIL burst_k%0d_bus: got %h/%0b want %h/%0b", k, bus.mem_addr, bus.mem_memWrt, e_addr, e_wrt); end
                tests_run++; if (bus.rvalid0 !== e_rv0 || (e_rv0 && bus.rdata0 !== m_rd0)) begin tests_failed++; $display("FAIL burst_k%0d_rd: got %0b/%h want %0b/%h", k, bus.rvalid0, bus.rdata0, e_rv0, m_rd0); end
            end else if (k == 0) begin
                tests_run++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin tests_failed++; $display("FAIL burst_k0_gnt: got %0b%0b want 00", bus.gnt0, bus.gnt1); end
            end
            if (m_b0) rem0--;
            if (m_b1) rem1--;
            advance();
        end
        idle_inputs();
        for (int k = 0; k < 2; k++) begin #1; model_eval(); advance(); end
    endtask

    task automatic test_tie();
        int want;
        apply_reset();
        for (int t = 0; t < 2; t++) begin
            bus.req0 = 1; bus.req1 = 1; bus.wr0 = 1; bus.wr1 = 1;
            bus.addr0 = 32'h5; bus.addr1 = 32'h6;
            #1; model_eval(); advance();
            bus.req0 = 0; bus.req1 = 0;
            #1; model_eval();
`ifdef MEM_ARB_RR_EN
            want = t;
`else
            want = 0;
`endif
            tests_run++; if (bus.gnt0 !== (want == 0) || bus.gnt1 !== (want == 1)) begin tests_failed++; $display("FAIL tie%0d_gnt: got %0b%0b want owner %0d", t, bus.gnt0, bus.gnt1, want); end
            tests_run++; if (bus.mem_memWrt !== 1'b0 || bus.mem_addr !== '0) begin tests_failed++; $display("FAIL tie%0d_nobeat: got wrt=%0b addr=%h want 0/0", t, bus.mem_memWrt, bus.mem_addr); end
            advance();
            #1; model_eval();
            tests_run++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin tests_failed++; $display("FAIL tie%0d_idle: got %0b%0b want 00", t, bus.gnt0, bus.gnt1); end
            advance();
        end
    endtask

    task automatic test_long_owner();
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            bus.req1 = (k <= 10); bus.wr1 = 1'($urandom_range(0, 1));
            bus.addr1 = $urandom; bus.wdata1 = $urandom;
            #1; model_eval();
            tests_run++; if (bus.gnt1 !== (k >= 1) || bus.gnt0 !== 1'b0) begin tests_failed++; $display("FAIL long_k%0d_gnt: got %0b%0b want 0%0b", k, bus.gnt0, bus.gnt1, (k >= 1)); end
            tests_run++; if (bus.mem_memWrt !== ((k >= 1 && k <= 10) && bus.wr1)) begin tests_failed++; $display("FAIL long_k%0d_wrt: got %0b", k, bus.mem_memWrt); end
            tests_run++; if (bus.rvalid1 !== e_rv1 || bus.rdata1 !== m_rd1) begin tests_failed++; $display("FAIL long_k%0d_rd: got %0b/%h want %0b/%h", k, bus.rvalid1, bus.rdata1, e_rv1, m_rd1); end
            advance();
        end
        idle_inputs();
        #1; model_eval(); advance();
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] v;
        apply_reset();
        v = $urandom | 32'h1;
        bus.req0 = 1; bus.wr0 = 1; bus.addr0 = 32'h3; bus.wdata0 = v;
        #1; model_eval(); advance();
        #1; model_eval(); advance();
        bus.wr0 = 0;
        #1; model_eval(); advance();
        #1; model_eval();
        tests_run++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== v || bus.gnt0 !== 1'b1) begin tests_failed++; $display("FAIL mid_pre: got rv=%0b rd=%h gnt=%0b want 1/%h/1", bus.rvalid0, bus.rdata0, bus.gnt0, v); end
        #1 rst = 1;
        #1;
        tests_run++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin tests_failed++; $display("FAIL mid_gnt: got %0b%0b want 00", bus.gnt0, bus.gnt1); end
        tests_run++; if (bus.mem_memWrt !== 1'b0 || bus.rvalid0 !== 1'b0) begin tests_failed++; $display("FAIL mid_wrt_rv: got %0b/%0b want 0/0", bus.mem_memWrt, bus.rvalid0); end
        @(negedge clk);
        rst = 0; bus.req0 = 0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            #1; model_eval();
            tests_run++; if (bus.rvalid0 !== 1'b0 || bus.gnt0 !== 1'b0) begin tests_failed++; $display("FAIL mid_after%0d: got rv=%0b gnt=%0b want 0/0", k, bus.rvalid0, bus.gnt0); end
            advance();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) < 2) bus.req0 = ~bus.req0;
            if ($urandom_range(0, 9) < 2) bus.req1 = ~bus.req1;
            bus.wr0 = 1'($urandom_range(0, 1)); bus.addr0 = $urandom; bus.wdata0 = $urandom;
            bus.wr1 = 1'($urandom_range(0, 1)); bus.addr1 = $urandom; bus.wdata1 = $urandom;
            #1; model_eval();
            tests_run++; if (bus.gnt0 !== e_gnt0 || bus.gnt1 !== e_gnt1) begin tests_failed++; $display("FAIL rnd%0d_gnt: got %0b%0b want %0b%0b", k, bus.gnt0, bus.gnt1, e_gnt0, e_gnt1); end
            tests_run++; if (bus.gnt0 && bus.gnt1) begin tests_failed++; $display("FAIL rnd%0d_both: got 11 want at most one", k); end
            tests_run++; if (bus.mem_addr !== e_addr || bus.mem_Din !== e_din || bus.mem_memWrt !== e_wrt) begin tests_failed++; $display("FAIL rnd%0d_bus: got %h/%h/%0b want %h/%h/%0b", k, bus.mem_addr, bus.mem_Din, bus.mem_memWrt, e_addr, e_din, e_wrt); end
            tests_run++; if (bus.mem_memWrt && !((bus.gnt0 && bus.req0 && bus.wr0) || (bus.gnt1 && bus.req1 && bus.wr1))) begin tests_failed++; $display("FAIL rnd%0d_wrt_owner: got write with no granted writer", k); end
            tests_run++; if (bus.rvalid0 !== e_rv0 || bus.rdata0 !== m_rd0) begin tests_failed++; $display("FAIL rnd%0d_rd0: got %0b/%h want %0b/%h", k, bus.rvalid0, bus.rdata0, e_rv0, m_rd0); end
            tests_run++; if (bus.rvalid1 !== e_rv1 || bus.rdata1 !== m_rd1) begin tests_failed++; $display("FAIL rnd%0d_rd1: got %0b/%h want %0b/%h", k, bus.rvalid1, bus.rdata1, e_rv1, m_rd1); end
            tests_run++; if ((bus.state_dbg != 2'd0) !== (e_gnt0 || e_gnt1)) begin tests_failed++; $display("FAIL rnd%0d_state: got %0d want owner %0d", k, bus.state_dbg, m_own); end
            advance();
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin #1; model_eval(); advance(); end
    endtask

    initial begin
        rst = 1; mem_clr = 1;
        idle_inputs();
        model_reset();
        test_reset();
        test_write_read();
        test_burst_alternation();
        test_tie();
        test_long_owner();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
